// File: rtl/riscv_dmem_resp.sv
// Data-memory responder for the core data bus: one transfer at a time, programmable wait
// states, alignment and range checking, byte-writable internal word array.
module riscv_dmem_resp #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] BASE_ADDR   = '0,
    parameter int unsigned     DEPTH       = 1024,
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic [XLEN-1:0]   mem_adr,
    input  logic              mem_we,
    input  logic [XLEN/8-1:0] mem_be,
    input  logic [XLEN-1:0]   mem_d,
    output logic [XLEN-1:0]   mem_q,
    output logic              mem_ack,
    output logic              mem_misaligned,
    output logic              mem_page_fault
);
    localparam int unsigned NB   = XLEN / 8;
    localparam int unsigned OFFW = $clog2(NB);
    localparam int unsigned IDXW = $clog2(DEPTH);
    localparam int unsigned CNTW = 4;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0] lat_adr, lat_d;
    logic            lat_we;
    logic [NB-1:0]   lat_be;

    logic [XLEN-1:0] cur_adr, cur_d, rel_c, rd_word_c;
    logic            cur_we, mis_c, pf_c, err_c, enter_ack_c, wr_en_c;
    logic [NB-1:0]   cur_be;
    logic [IDXW-1:0] idx_c;

    logic [XLEN-1:0] mem [DEPTH];

    // be must be a naturally aligned, power-of-two sized run of lanes starting at the offset
    function automatic logic be_ok(input logic [NB-1:0] be, input logic [OFFW-1:0] off);
        logic          ok;
        logic [NB-1:0] m;
        int unsigned   o;
        ok = 1'b0;
        o  = 32'(off);
        for (int unsigned k = 0; k <= OFFW; k++) begin
            m = '0;
            for (int unsigned i = 0; i < NB; i++) begin
                if (i >= o && i < o + (32'd1 << k)) m[i] = 1'b1;
            end
            if ((o & ((32'd1 << k) - 32'd1)) == 32'd0 && be == m) ok = 1'b1;
        end
        return ok;
    endfunction

    // In IDLE the live bus is evaluated; afterwards the latched copy drives the access
    always_comb begin
        cur_adr   = (state == S_IDLE) ? mem_adr : lat_adr;
        cur_we    = (state == S_IDLE) ? mem_we  : lat_we;
        cur_be    = (state == S_IDLE) ? mem_be  : lat_be;
        cur_d     = (state == S_IDLE) ? mem_d   : lat_d;
        rel_c     = cur_adr - BASE_ADDR;
        idx_c     = rel_c[OFFW +: IDXW];
        pf_c      = (cur_adr < BASE_ADDR) || ((rel_c >> OFFW) >= XLEN'(DEPTH));
        mis_c     = !be_ok(cur_be, cur_adr[OFFW-1:0]);
        err_c     = pf_c || mis_c;
        rd_word_c = mem[idx_c];
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        enter_ack_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req) begin
                    if (err_c || WAIT_STATES == 0) begin
                        state_nxt   = S_ACK;
                        enter_ack_c = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNTW'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt   = S_ACK;
                    enter_ack_c = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign wr_en_c = enter_ack_c && cur_we && !err_c && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lat_adr        <= '0;
            lat_we         <= 1'b0;
            lat_be         <= '0;
            lat_d          <= '0;
            mem_q          <= '0;
            mem_ack        <= 1'b0;
            mem_misaligned <= 1'b0;
            mem_page_fault <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == S_IDLE && mem_req) begin
                lat_adr <= mem_adr;
                lat_we  <= mem_we;
                lat_be  <= mem_be;
                lat_d   <= mem_d;
            end
            mem_ack        <= enter_ack_c;
            mem_misaligned <= enter_ack_c && mis_c;
            mem_page_fault <= enter_ack_c && pf_c;
            mem_q          <= (enter_ack_c && !cur_we && !err_c) ? rd_word_c : '0;
        end
    end

    // Storage is not reset; only enabled lanes are written
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (cur_be[i]) mem[idx_c][8*i +: 8] <= cur_d[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Bench for riscv_dmem_resp: two instances (0 and 3 wait states) checked every cycle against
// a transaction-level model, plus directed transfers with literal expectations.
module tb_riscv_dmem_resp;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WSA   = 0;
    localparam int          WSB   = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]       req, we, ack, mis, pf;
    logic [1:0][31:0] adr, d, q;
    logic [1:0][3:0]  be;

    int checks = 0;
    int errors = 0;

    riscv_dmem_resp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(WSA)) u_ws0 (
        .clk(clk), .rst(rst), .mem_req(req[0]), .mem_adr(adr[0]), .mem_we(we[0]),
        .mem_be(be[0]), .mem_d(d[0]), .mem_q(q[0]), .mem_ack(ack[0]),
        .mem_misaligned(mis[0]), .mem_page_fault(pf[0]));

    riscv_dmem_resp #(.XLEN(32), .BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(WSB)) u_ws3 (
        .clk(clk), .rst(rst), .mem_req(req[1]), .mem_adr(adr[1]), .mem_we(we[1]),
        .mem_be(be[1]), .mem_d(d[1]), .mem_q(q[1]), .mem_ack(ack[1]),
        .mem_misaligned(mis[1]), .mem_page_fault(pf[1]));

    task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", nm, i, got, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int          cyc = 0;
    bit          pend [2];
    int          ack_at [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_d [2];
    logic [3:0]  m_be [2];
    logic        m_we [2];
    bit          m_mis [2];
    bit          m_pf [2];
    logic        exp_ack [2];
    logic        exp_mis [2];
    logic        exp_pf [2];
    logic [31:0] exp_q [2];
    logic [31:0] mm [2][DEPTH];
    bit          t_blk;
    int          t_idx;

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = 0; ack_at[i] = 0; exp_ack[i] = 0; exp_mis[i] = 0; exp_pf[i] = 0; exp_q[i] = '0;
        end
    end

    function automatic void classify(input logic [31:0] a, input logic [3:0] b,
                                     output bit f_mis, output bit f_pf);
        int n, off;
        logic [3:0] run;
        f_pf = (a < BASE) || (((a - BASE) / 4) >= DEPTH);
        n    = $countones(b);
        off  = int'(a % 4);
        f_mis = 1;
        if (n == 1 || n == 2 || n == 4) begin
            run = 4'(((1 << n) - 1) << off);
            if (off % n == 0 && b == run) f_mis = 0;
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                pend[i] = 0; exp_ack[i] = 0; exp_mis[i] = 0; exp_pf[i] = 0; exp_q[i] = '0;
            end
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                // the edge closing the ack cycle never accepts a request
                t_blk = pend[i] && (cyc == ack_at[i] + 1);
                if (t_blk) pend[i] = 0;
                if (!pend[i] && !t_blk && req[i]) begin
                    m_adr[i] = adr[i]; m_we[i] = we[i]; m_be[i] = be[i]; m_d[i] = d[i];
                    classify(adr[i], be[i], m_mis[i], m_pf[i]);
                    pend[i]   = 1;
                    ack_at[i] = cyc + ((m_mis[i] || m_pf[i]) ? 0 : ((i == 0) ? WSA : WSB));
                end
                exp_ack[i] = 0; exp_mis[i] = 0; exp_pf[i] = 0; exp_q[i] = '0;
                if (pend[i] && cyc == ack_at[i]) begin
                    exp_ack[i] = 1; exp_mis[i] = m_mis[i]; exp_pf[i] = m_pf[i];
                    if (!m_mis[i] && !m_pf[i]) begin
                        t_idx = int'((m_adr[i] - BASE) / 4);
                        if (m_we[i]) begin
                            for (int l = 0; l < 4; l++)
                                if (m_be[i][l]) mm[i][t_idx][8*l +: 8] = m_d[i][8*l +: 8];
                        end else begin
                            exp_q[i] = mm[i][t_idx];
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("ack", i, 32'(ack[i]), 32'(exp_ack[i]));
            chk("mis", i, 32'(mis[i]), 32'(exp_mis[i]));
            chk("pf",  i, 32'(pf[i]),  32'(exp_pf[i]));
            chk("q",   i, q[i], exp_q[i]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic xfer(input int i, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] dd, output logic [31:0] rq, output logic rm,
                        output logic rp, output int n);
        req[i] = 1'b1; adr[i] = a; we[i] = w; be[i] = b; d[i] = dd;
        n = 0; rq = '0; rm = 1'b0; rp = 1'b0;
        while (n <= 40) begin
            @(posedge clk); #1;
            n++;
            if (ack[i]) begin
                rq = q[i]; rm = mis[i]; rp = pf[i];
                break;
            end
        end
        if (n > 40) begin
            checks++; errors++;
            $display("FAIL timeout dut%0d adr %h got no ack expected ack", i, a);
        end
        req[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [31:0] rq;
    logic        rm, rp;
    int          n, seen;

    initial begin
        req = '0; we = '0; adr = '0; d = '0; be = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 0, 32'(ack[0]), 32'd0);
        chk("rst_q",   1, q[1], 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // zero wait states: write then read back
        xfer(0, BASE + 32'h8, 1'b1, 4'hF, 32'hDEADBEEF, rq, rm, rp, n);
        chk("t1_wr_lat", 0, 32'(n), 32'd1);
        xfer(0, BASE + 32'h8, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t1_rd_lat", 0, 32'(n), 32'd1);
        chk("t1_rd_q",   0, rq, 32'hDEADBEEF);

        // three wait states
        xfer(1, BASE + 32'h8, 1'b1, 4'hF, 32'h12345678, rq, rm, rp, n);
        chk("t2_wr_lat", 1, 32'(n), 32'd4);
        xfer(1, BASE + 32'h8, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t2_rd_lat", 1, 32'(n), 32'd4);
        chk("t2_rd_q",   1, rq, 32'h12345678);

        // single byte lane update
        xfer(0, BASE + 32'h8, 1'b1, 4'hF, 32'h11223344, rq, rm, rp, n);
        xfer(0, BASE + 32'hA, 1'b1, 4'b0100, 32'h00AA0000, rq, rm, rp, n);
        chk("t3_bw_mis", 0, 32'(rm), 32'd0);
        xfer(0, BASE + 32'h8, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t3_rd_q", 0, rq, 32'h11AA3344);
        xfer(0, BASE + 32'hA, 1'b0, 4'b1100, 32'h0, rq, rm, rp, n);
        chk("t3_half_q", 0, rq, 32'h11AA3344);

        // misaligned writes leave the array untouched
        xfer(0, BASE, 1'b1, 4'hF, 32'hCAFEF00D, rq, rm, rp, n);
        xfer(0, BASE + 32'h2, 1'b1, 4'hF, 32'hFFFFFFFF, rq, rm, rp, n);
        chk("t4a_lat", 0, 32'(n), 32'd1);
        chk("t4a_mis", 0, 32'(rm), 32'd1);
        chk("t4a_pf",  0, 32'(rp), 32'd0);
        xfer(0, BASE + 32'h1, 1'b1, 4'b0110, 32'hFFFFFFFF, rq, rm, rp, n);
        chk("t4b_mis", 0, 32'(rm), 32'd1);
        xfer(1, BASE + 32'h4, 1'b1, 4'b0000, 32'hFFFFFFFF, rq, rm, rp, n);
        chk("t4c_lat", 1, 32'(n), 32'd1);
        chk("t4c_mis", 1, 32'(rm), 32'd1);
        xfer(0, BASE, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t4_rdback", 0, rq, 32'hCAFEF00D);

        // range limits, with wait states skipped on error
        xfer(1, BASE + 32'(4 * DEPTH), 1'b1, 4'hF, 32'hFFFFFFFF, rq, rm, rp, n);
        chk("t5a_lat", 1, 32'(n), 32'd1);
        chk("t5a_pf",  1, 32'(rp), 32'd1);
        chk("t5a_mis", 1, 32'(rm), 32'd0);
        xfer(1, BASE - 32'h4, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t5b_pf", 1, 32'(rp), 32'd1);
        chk("t5b_q",  1, rq, 32'h0);
        xfer(1, BASE - 32'h3, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t5c_both", 1, 32'({rp, rm}), 32'd3);
        xfer(1, BASE + 32'(4 * (DEPTH - 1)), 1'b1, 4'hF, 32'hA5A5_0F0F, rq, rm, rp, n);
        xfer(1, BASE + 32'(4 * (DEPTH - 1)), 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t5d_last_q", 1, rq, 32'hA5A5_0F0F);
        chk("t5d_pf",     1, 32'(rp), 32'd0);

        // reset during the wait states of a write
        xfer(1, BASE + 32'h20, 1'b1, 4'hF, 32'h0, rq, rm, rp, n);
        req[1] = 1'b1; adr[1] = BASE + 32'h20; we[1] = 1'b1; be[1] = 4'hF; d[1] = 32'h55555555;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_ack", 1, 32'(ack[1]), 32'd0);
        chk("t6_q",   1, q[1], 32'd0);
        req[1] = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[1]) seen++;
        end
        chk("t6_no_ack", 1, 32'(seen), 32'd0);
        xfer(1, BASE + 32'h20, 1'b0, 4'hF, 32'h0, rq, rm, rp, n);
        chk("t6_rd_q", 1, rq, 32'h0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
